// File: rtl/key_note_encoder.sv
// rtl/key_note_encoder.sv - synchronise, debounce and priority-encode 16 piano keys into {note_en, note}
module key_note_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int RELEASE_CYCLES  = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] keys_raw,
    output logic [3:0]  note,
    output logic        note_en,
    output logic        note_change
);

    localparam int DCW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RCW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [DCW-1:0] DC_MAX  = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCW-1:0] RC_LOAD = (RELEASE_CYCLES > 0) ? RCW'(RELEASE_CYCLES - 1) : RCW'(0);
    localparam bit SUSTAIN_EN = (RELEASE_CYCLES > 0);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PLAY    = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    logic [15:0]    sync1_q, sync1_d;
    logic [15:0]    sync_q, sync_d;
    logic [15:0]    cand_q, cand_d;
    logic [DCW-1:0] cnt_q, cnt_d;
    logic [15:0]    stable_q, stable_d;

    state_t         state_q, state_d;
    logic [3:0]     note_q, note_d;
    logic           note_en_q, note_en_d;
    logic           note_change_q, note_change_d;
    logic [RCW-1:0] rel_cnt_q, rel_cnt_d;

    logic [3:0]     sel;
    logic           any;

    always_comb begin
        sync1_d = keys_raw;
        sync_d  = sync1_q;
    end

    // Whole-vector debounce: any change in the synchronised vector restarts the count.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync_q != cand_q) begin
            cand_d = sync_q;
            cnt_d  = '0;
        end else if (cnt_q == DC_MAX) begin
            stable_d = cand_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Ascending scan so the highest set bit is the last one written.
    always_comb begin
        sel = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (stable_q[i]) begin
                sel = 4'(i);
            end
        end
        any = |stable_q;
    end

    always_comb begin
        state_d   = state_q;
        note_d    = note_q;
        note_en_d = note_en_q;
        rel_cnt_d = rel_cnt_q;
        case (state_q)
            S_IDLE: begin
                note_en_d = 1'b0;
                if (any) begin
                    state_d   = S_PLAY;
                    note_d    = sel;
                    note_en_d = 1'b1;
                end
            end
            S_PLAY: begin
                note_en_d = 1'b1;
                if (any) begin
                    note_d = sel;
                end else if (SUSTAIN_EN) begin
                    state_d   = S_RELEASE;
                    rel_cnt_d = RC_LOAD;
                end else begin
                    state_d   = S_IDLE;
                    note_en_d = 1'b0;
                end
            end
            S_RELEASE: begin
                note_en_d = 1'b1;
                if (any) begin
                    state_d = S_PLAY;
                    note_d  = sel;
                end else if (rel_cnt_q == '0) begin
                    state_d   = S_IDLE;
                    note_en_d = 1'b0;
                end else begin
                    rel_cnt_d = rel_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                note_en_d = 1'b0;
            end
        endcase
        // Pulse exactly when the value presented to the decoder changes.
        note_change_d = (note_en_d != note_en_q) || (note_d != note_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q       <= '0;
            sync_q        <= '0;
            cand_q        <= '0;
            cnt_q         <= '0;
            stable_q      <= '0;
            state_q       <= S_IDLE;
            note_q        <= '0;
            note_en_q     <= 1'b0;
            note_change_q <= 1'b0;
            rel_cnt_q     <= '0;
        end else begin
            sync1_q       <= sync1_d;
            sync_q        <= sync_d;
            cand_q        <= cand_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            state_q       <= state_d;
            note_q        <= note_d;
            note_en_q     <= note_en_d;
            note_change_q <= note_change_d;
            rel_cnt_q     <= rel_cnt_d;
        end
    end

    assign note        = note_q;
    assign note_en     = note_en_q;
    assign note_change = note_change_q;

endmodule

// File: tb/tb_key_note_encoder.sv
// tb/tb_key_note_encoder.sv - directed self-checking bench for key_note_encoder
module tb_key_note_encoder;

    logic        clk;
    logic        reset_n;
    logic [15:0] keys_raw;
    logic [3:0]  note;
    logic        note_en;
    logic        note_change;
    logic [3:0]  note_z;
    logic        note_en_z;
    logic        note_change_z;

    int checks = 0;
    int errors = 0;

    key_note_encoder #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(8)) dut (
        .clk(clk), .reset_n(reset_n), .keys_raw(keys_raw),
        .note(note), .note_en(note_en), .note_change(note_change)
    );

    key_note_encoder #(.DEBOUNCE_CYCLES(4), .RELEASE_CYCLES(0)) dut_r0 (
        .clk(clk), .reset_n(reset_n), .keys_raw(keys_raw),
        .note(note_z), .note_en(note_en_z), .note_change(note_change_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [15:0] v);
        @(negedge clk);
        keys_raw = v;
    endtask

    task automatic test_reset();
        reset_n  = 1'b0;
        keys_raw = 16'hFFFF;
        repeat (3) step();
        checks++;
        if (note !== 4'd0 || note_en !== 1'b0 || note_change !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got note=%0d en=%b chg=%b expected 0 0 0", note, note_en, note_change);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            step();
            if (e == 7) begin
                checks++;
                if (note_en !== 1'b0 || note_change !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_early: got en=%b chg=%b expected 0 0 at edge 7", note_en, note_change);
                end
            end
            if (e == 8) begin
                checks++;
                if (note !== 4'd15 || note_en !== 1'b1 || note_change !== 1'b1) begin
                    errors++;
                    $display("FAIL reset_first_note: got note=%0d en=%b chg=%b expected 15 1 1", note, note_en, note_change);
                end
            end
            if (e == 9) begin
                checks++;
                if (note_change !== 1'b0 || note !== 4'd15) begin
                    errors++;
                    $display("FAIL reset_pulse_width: got note=%0d chg=%b expected 15 0", note, note_change);
                end
            end
        end
        set_keys(16'h0000);
        repeat (30) step();
        checks++;
        if (note_en !== 1'b0 || note !== 4'd15) begin
            errors++;
            $display("FAIL idle_hold_note: got note=%0d en=%b expected 15 0", note, note_en);
        end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int p = 0; p < 10; p++) begin
            set_keys((p % 2 == 0) ? 16'h0020 : 16'h0000);
            repeat (2) begin
                step();
                if (note_en !== 1'b0 || note_change !== 1'b0) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_reject: got %0d cycles with output activity expected 0", bad);
        end
        set_keys(16'h0020);
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) begin
                checks++;
                if (note_en !== 1'b0) begin
                    errors++;
                    $display("FAIL bounce_early: got en=%b expected 0 at edge 7", note_en);
                end
            end
        end
        checks++;
        if (note !== 4'd5 || note_en !== 1'b1 || note_change !== 1'b1) begin
            errors++;
            $display("FAIL bounce_settle: got note=%0d en=%b chg=%b expected 5 1 1", note, note_en, note_change);
        end
    endtask

    task automatic test_priority();
        int pulses;
        int drops;
        set_keys(16'h0208);
        repeat (8) step();
        checks++;
        if (note !== 4'd9 || note_en !== 1'b1 || note_change !== 1'b1) begin
            errors++;
            $display("FAIL priority_top: got note=%0d en=%b chg=%b expected 9 1 1", note, note_en, note_change);
        end
        set_keys(16'h0008);
        pulses = 0;
        drops  = 0;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (note_change === 1'b1) pulses++;
            if (note_en !== 1'b1) drops++;
            if (e == 8) begin
                checks++;
                if (note !== 4'd3 || note_change !== 1'b1) begin
                    errors++;
                    $display("FAIL priority_fall: got note=%0d chg=%b expected 3 1", note, note_change);
                end
            end
        end
        checks++;
        if (pulses != 1 || drops != 0) begin
            errors++;
            $display("FAIL priority_no_release: got pulses=%0d en_drops=%0d expected 1 0", pulses, drops);
        end
    endtask

    task automatic test_sustain();
        int bad;
        bad = 0;
        set_keys(16'h0000);
        for (int e = 1; e <= 17; e++) begin
            step();
            if (e >= 8 && e <= 15) begin
                if (note_en !== 1'b1 || note_change !== 1'b0 || note !== 4'd3) bad++;
            end
            if (e == 7) begin
                checks++;
                if (note_en_z !== 1'b1 || note_z !== 4'd3) begin
                    errors++;
                    $display("FAIL r0_before: got note=%0d en=%b expected 3 1", note_z, note_en_z);
                end
            end
            if (e == 8) begin
                checks++;
                if (note_en_z !== 1'b0 || note_change_z !== 1'b1 || note_z !== 4'd3) begin
                    errors++;
                    $display("FAIL r0_fall: got note=%0d en=%b chg=%b expected 3 0 1", note_z, note_en_z, note_change_z);
                end
            end
            if (e == 16) begin
                checks++;
                if (note_en !== 1'b0 || note_change !== 1'b1 || note !== 4'd3) begin
                    errors++;
                    $display("FAIL sustain_fall: got note=%0d en=%b chg=%b expected 3 0 1", note, note_en, note_change);
                end
            end
            if (e == 17) begin
                checks++;
                if (note_change !== 1'b0 || note_en !== 1'b0) begin
                    errors++;
                    $display("FAIL sustain_after: got en=%b chg=%b expected 0 0", note_en, note_change);
                end
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL sustain_hold: got %0d bad cycles in release window expected 0", bad);
        end
    endtask

    task automatic test_retrigger();
        int drops;
        int pulses;
        set_keys(16'h0004);
        repeat (10) step();
        checks++;
        if (note !== 4'd2 || note_en !== 1'b1) begin
            errors++;
            $display("FAIL retrig_setup: got note=%0d en=%b expected 2 1", note, note_en);
        end
        set_keys(16'h0000);
        repeat (6) step();
        set_keys(16'h0080);
        drops = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (note_en !== 1'b1) drops++;
        end
        checks++;
        if (note !== 4'd7 || note_change !== 1'b1 || drops != 0) begin
            errors++;
            $display("FAIL retrig_new_key: got note=%0d chg=%b en_drops=%0d expected 7 1 0", note, note_change, drops);
        end
        set_keys(16'h0004);
        repeat (12) step();
        set_keys(16'h0000);
        repeat (6) step();
        set_keys(16'h0004);
        drops  = 0;
        pulses = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (note_en !== 1'b1) drops++;
            if (note_change === 1'b1) pulses++;
        end
        checks++;
        if (note !== 4'd2 || pulses != 0 || drops != 0) begin
            errors++;
            $display("FAIL retrig_same_key: got note=%0d pulses=%0d en_drops=%0d expected 2 0 0", note, pulses, drops);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (note !== 4'd0 || note_en !== 1'b0 || note_change !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got note=%0d en=%b chg=%b expected 0 0 0", note, note_en, note_change);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 7) begin
                checks++;
                if (note_en !== 1'b0) begin
                    errors++;
                    $display("FAIL async_relatch_early: got en=%b expected 0 at edge 7", note_en);
                end
            end
        end
        checks++;
        if (note !== 4'd2 || note_en !== 1'b1 || note_change !== 1'b1) begin
            errors++;
            $display("FAIL async_relatch: got note=%0d en=%b chg=%b expected 2 1 1", note, note_en, note_change);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        keys_raw = 16'hFFFF;
        test_reset();
        test_bounce();
        test_priority();
        test_sustain();
        test_retrigger();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
